demux_1to7_32bits_buffered: RTL

//   Buffered 1-to-7 distributor for 32-bit words: the routing inverse of the datapath 7:1 selectors.

---
 rtl/demux_1to7_32bits_buffered.sv | 102 ++++++++++
 1 files changed

// File: rtl/demux_1to7_32bits_buffered.sv
// Buffered 1-to-N distributor: queues {word, destination} and presents the head word
// to one consumer channel at a time over a valid/ready handshake.
module demux_1to7_32bits_buffered #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_OUT  = 7,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    input  logic              clr_err,
    output logic              err_sel,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SEL_W = 3;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEL_W-1:0]  mem_sel  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              sel_ok, accept, push, drop, pop;
    logic [DATA_W-1:0] head_data_n;
    logic [SEL_W-1:0]  head_sel_n;
    logic [DATA_W-1:0] out_data_n;
    logic [N_OUT-1:0]  out_valid_n;
    logic              in_ready_n;
    logic              err_sel_n;
    logic [7:0]        drop_cnt_n;

    // Next-state: queue bookkeeping and the registered view of the next head entry.
    always_comb begin
        sel_ok      = 32'(in_sel) < N_OUT;
        accept      = in_valid && in_ready;
        push        = accept && sel_ok;
        drop        = accept && !sel_ok;
        pop         = |(out_valid & out_ready);
        wr_ptr_n    = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n    = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n     = count + CNT_W'(push) - CNT_W'(pop);
        head_data_n = mem_data[rd_ptr_n];
        head_sel_n  = mem_sel[rd_ptr_n];
        out_data_n  = '0;
        out_valid_n = '0;
        // Queue drains to nothing but the word being written: it becomes the head.
        if (count == CNT_W'(pop)) begin
            head_data_n = in_data;
            head_sel_n  = in_sel;
        end
        if (count_n != '0) begin
            out_data_n  = head_data_n;
            out_valid_n = N_OUT'(1) << head_sel_n;
        end
        in_ready_n  = count_n != CNT_W'(DEPTH);
        drop_cnt_n  = (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        err_sel_n   = drop ? 1'b1 : (clr_err ? 1'b0 : err_sel);
    end

    // Storage write; contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_sel[wr_ptr]  <= in_sel;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            err_sel   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
            busy      <= count_n != '0;
            err_sel   <= err_sel_n;
            drop_cnt  <= drop_cnt_n;
        end
    end

endmodule
